systolic_skew_feeder: RTL and testbench

Operand feeder that sits directly downstream of the row/column index counter in the matrix-multiply datapath. It captures one N×N operand tile streamed element-by-element, tagged with the counter's `pixel_cntr`/`slice_cntr` indices. It then replays the tile into the systolic array as a diagonal wavefront: lane r is delayed r cycles and zero-filled outside its window. It also drives the counter's row-advance enable, so the index stream stalls while a tile is being fed.

---
 rtl/matmul_pkg.sv | 18 +
 rtl/tile_buf.sv | 33 +++
 rtl/systolic_skew_feeder.sv | 155 +++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply datapath.
// FSM state enum, default sizes and a safe clog2.
package matmul_pkg;

  typedef enum logic [1:0] {
    FD_IDLE,
    FD_LOAD,
    FD_FEED
  } fd_state_e;

  localparam int MM_N      = 4;
  localparam int MM_DATA_W = 8;

  function automatic int clog2s(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/tile_buf.sv
// N x N operand tile storage: one write port, N lane read ports.
// Contents are deliberately not reset.
module tile_buf
  import matmul_pkg::*;
#(
  parameter int N      = MM_N,
  parameter int DATA_W = MM_DATA_W,
  parameter int IDX_W  = clog2s(N)
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [IDX_W-1:0]              i_wr_row,
  input  logic [IDX_W-1:0]              i_wr_col,
  input  logic [DATA_W-1:0]             i_wr_data,
  input  logic [N-1:0][IDX_W-1:0]       i_rd_row,
  input  logic [N-1:0][IDX_W-1:0]       i_rd_col,
  output logic [N-1:0][DATA_W-1:0]      o_rd_data
);

  logic [DATA_W-1:0] r_mem [N][N];

  // single synchronous write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_row][i_wr_col] <= i_wr_data;
  end

  // one combinational read per lane
  always_comb begin
    for (int l = 0; l < N; l++)
      o_rd_data[l] = r_mem[i_rd_row[l]][i_rd_col[l]];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Captures an N x N tile in row-major order, then replays it skewed.
// Define SKEW_FEEDER_TRANSPOSE_EN for a column-major (B operand) feed.
module systolic_skew_feeder
  import matmul_pkg::*;
#(
  parameter int N      = MM_N,
  parameter int DATA_W = MM_DATA_W,
  parameter int IDX_W  = clog2s(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [IDX_W-1:0]    pixel_cntr,
  input  logic [IDX_W-1:0]    slice_cntr,
  output logic                in_ready,
  output logic                row_cnt_en,
  input  logic                feed_en,
  output logic [N-1:0]        out_valid,
  output logic [N*DATA_W-1:0] out_data,
  output logic                done,
  output logic                seq_err
);

  localparam int TW = clog2s(2*N-1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);
  localparam logic signed [TW:0] D_MAX = (TW+1)'(N-1);

  fd_state_e           r_state;
  logic [IDX_W-1:0]    r_exp_row;
  logic [IDX_W-1:0]    r_exp_col;
  logic [TW-1:0]       r_t;
  logic [N-1:0]        r_out_valid;
  logic [N*DATA_W-1:0] r_out_data;
  logic                r_done;
  logic                r_seq_err;

  logic                       w_first;
  logic                       w_idx_ok;
  logic                       w_we;
  logic signed [TW:0]         w_d [N];
  logic [N-1:0]               w_win;
  logic [N-1:0][IDX_W-1:0]    w_rd_row;
  logic [N-1:0][IDX_W-1:0]    w_rd_col;
  logic [N-1:0][DATA_W-1:0]   w_rd_data;
  logic [N*DATA_W-1:0]        w_step;

  assign in_ready   = (r_state != FD_FEED);
  assign row_cnt_en = in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign done       = r_done;
  assign seq_err    = r_seq_err;

  assign w_first  = (slice_cntr == '0) && (pixel_cntr == '0);
  assign w_idx_ok = (slice_cntr == r_exp_row) &&
                    (pixel_cntr == r_exp_col);
  assign w_we = in_valid &&
                (((r_state == FD_IDLE) && w_first) ||
                 ((r_state == FD_LOAD) && w_idx_ok));

  tile_buf #(
    .N      (N),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_row  (slice_cntr),
    .i_wr_col  (pixel_cntr),
    .i_wr_data (in_data),
    .i_rd_row  (w_rd_row),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_rd_data)
  );

  // skewed lane addressing and zero-fill for the current step
  always_comb begin
    w_win  = '0;
    w_step = '0;
    for (int r = 0; r < N; r++) begin
      w_d[r] = $signed({1'b0, r_t}) - $signed((TW+1)'(r));
      w_win[r] = !w_d[r][TW] && (w_d[r] <= D_MAX);
`ifdef SKEW_FEEDER_TRANSPOSE_EN
      w_rd_row[r] = w_win[r] ? w_d[r][IDX_W-1:0] : '0;
      w_rd_col[r] = IDX_W'(r);
`else
      w_rd_row[r] = IDX_W'(r);
      w_rd_col[r] = w_win[r] ? w_d[r][IDX_W-1:0] : '0;
`endif
      w_step[r*DATA_W +: DATA_W] =
        w_win[r] ? w_rd_data[r] : '0;
    end
  end

  // load/feed sequencing with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FD_IDLE;
      r_exp_row   <= '0;
      r_exp_col   <= '0;
      r_t         <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_seq_err   <= 1'b0;
      r_out_valid <= '0;
      unique case (r_state)
        FD_IDLE: begin
          if (in_valid && w_first) begin
            r_state   <= FD_LOAD;
            r_exp_row <= '0;
            r_exp_col <= IDX_W'(1);
          end
        end
        FD_LOAD: begin
          if (in_valid) begin
            if (!w_idx_ok) begin
              r_seq_err <= 1'b1;
              r_state   <= FD_IDLE;
            end else if (r_exp_row == LAST &&
                         r_exp_col == LAST) begin
              r_state <= FD_FEED;
              r_t     <= '0;
            end else if (r_exp_col == LAST) begin
              r_exp_col <= '0;
              r_exp_row <= r_exp_row + IDX_W'(1);
            end else begin
              r_exp_col <= r_exp_col + IDX_W'(1);
            end
          end
        end
        FD_FEED: begin
          if (feed_en) begin
            r_out_valid <= w_win;
            r_out_data  <= w_step;
            if (r_t == T_LAST) begin
              r_done  <= 1'b1;
              r_state <= FD_IDLE;
              r_t     <= '0;
            end else begin
              r_t <= r_t + TW'(1);
            end
          end
        end
        default: r_state <= FD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder.
// Reference model derives each wavefront from the tile array.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [IW-1:0] pixel_cntr = '0;
  logic [IW-1:0] slice_cntr = '0;
  logic          in_ready;
  logic          row_cnt_en;
  logic          feed_en = 1'b0;
  logic [N-1:0]  out_valid;
  logic [N*DW-1:0] out_data;
  logic          done;
  logic          seq_err;

  systolic_skew_feeder #(
    .N      (N),
    .DATA_W (DW),
    .IDX_W  (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .pixel_cntr (pixel_cntr),
    .slice_cntr (slice_cntr),
    .in_ready   (in_ready),
    .row_cnt_en (row_cnt_en),
    .feed_en    (feed_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .done       (done),
    .seq_err    (seq_err)
  );

  logic [DW-1:0]   m [N][N];
  logic [N*DW-1:0] last_d = '0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int t,
                                output logic [N-1:0] v,
                                output logic [N*DW-1:0] d);
    v = '0;
    d = '0;
    for (int r = 0; r < N; r++) begin
      int k;
      k = t - r;
      if (k >= 0 && k < N) begin
        v[r] = 1'b1;
`ifdef SKEW_FEEDER_TRANSPOSE_EN
        d[r*DW +: DW] = m[k][r];
`else
        d[r*DW +: DW] = m[r][k];
`endif
      end
    end
  endfunction

  task automatic fill_pattern();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = DW'(16 * r + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = DW'($urandom);
  endtask

  task automatic send(input int r, input int c, input logic [DW-1:0] d);
    in_valid   = 1'b1;
    slice_cntr = IW'(r);
    pixel_cntr = IW'(c);
    in_data    = d;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic load_tile(input bit gaps);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          tick();
          chk("gap_ready", 64'(in_ready), 64'd1);
        end
        chk("load_ready", 64'(in_ready), 64'd1);
        chk("load_rce", 64'(row_cnt_en), 64'd1);
        send(r, c, m[r][c]);
        chk("load_seq_err", 64'(seq_err), 64'd0);
        chk("load_valid", 64'(out_valid), 64'd0);
      end
    end
    chk("feed_ready", 64'(in_ready), 64'd0);
    chk("feed_rce", 64'(row_cnt_en), 64'd0);
  endtask

  task automatic feed(input int stall_at, input int stall_len);
    int t;
    int stalled;
    logic [N-1:0] ev;
    logic [N*DW-1:0] ed;
    t = 0;
    stalled = 0;
    while (t < 2 * N - 1) begin
      if (t == stall_at && stalled < stall_len) begin
        feed_en = 1'b0;
        tick();
        chk("stall_valid", 64'(out_valid), 64'd0);
        chk("stall_data", 64'(out_data), 64'(last_d));
        chk("stall_done", 64'(done), 64'd0);
        stalled++;
      end else begin
        feed_en = 1'b1;
        tick();
        model(t, ev, ed);
        chk($sformatf("valid_t%0d", t), 64'(out_valid), 64'(ev));
        chk($sformatf("data_t%0d", t), 64'(out_data), 64'(ed));
        chk($sformatf("done_t%0d", t), 64'(done),
            64'(t == 2 * N - 2));
        last_d = ed;
        t++;
      end
    end
    feed_en = 1'b0;
    chk("post_ready", 64'(in_ready), 64'd1);
    tick();
    chk("post_done", 64'(done), 64'd0);
    chk("post_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [N-1:0] ev;
    logic [N*DW-1:0] ed;

    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_seq_err", 64'(seq_err), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_rce", 64'(row_cnt_en), 64'd1);
    rst_n = 1'b1;
    tick();

    // scenario 1: pattern tile, feed_en high throughout
    fill_pattern();
    load_tile(1'b0);
    feed_en = 1'b1;
    for (int t = 0; t < 2 * N - 1; t++) begin
      tick();
      if (t == 0) begin
        chk("s1_v0", 64'(out_valid), 64'b0001);
        chk("s1_d0", 64'(out_data[DW-1:0]), 64'h00);
      end
      if (t == 3) begin
        chk("s1_v3", 64'(out_valid), 64'b1111);
`ifdef SKEW_FEEDER_TRANSPOSE_EN
        chk("s1_d3", 64'(out_data), 64'h03122130);
`else
        chk("s1_d3", 64'(out_data), 64'h30211203);
`endif
      end
      if (t == 6) begin
        chk("s1_v6", 64'(out_valid), 64'b1000);
        chk("s1_d6", 64'(out_data[3*DW +: DW]), 64'h33);
      end
      chk("s1_done", 64'(done), 64'(t == 6));
    end
    feed_en = 1'b0;
    model(6, ev, ed);
    last_d = ed;
    tick();
    chk("s1_done_pulse", 64'(done), 64'd0);

    // scenario 2: stall two cycles before step 2
    load_tile(1'b0);
    feed(2, 2);

    // scenario 3: index sequence violation
    send(0, 0, 8'hAA);
    chk("s3_err0", 64'(seq_err), 64'd0);
    send(0, 1, 8'hBB);
    chk("s3_err1", 64'(seq_err), 64'd0);
    send(0, 3, 8'hCC);
    chk("s3_err_pulse", 64'(seq_err), 64'd1);
    chk("s3_ready", 64'(in_ready), 64'd1);
    chk("s3_valid", 64'(out_valid), 64'd0);
    tick();
    chk("s3_err_clear", 64'(seq_err), 64'd0);
    chk("s3_valid2", 64'(out_valid), 64'd0);
    send(0, 2, 8'hDD);
    chk("s3_idle_ign", 64'(seq_err), 64'd0);
    chk("s3_idle_ready", 64'(in_ready), 64'd1);

    // scenario 4: non-origin index in IDLE is ignored
    send(1, 2, 8'hEE);
    chk("s4_ready", 64'(in_ready), 64'd1);
    chk("s4_err", 64'(seq_err), 64'd0);
    fill_random();
    load_tile(1'b1);
    feed(-1, 0);

    // scenario 5: async reset during feed step 4
    fill_pattern();
    load_tile(1'b0);
    feed_en = 1'b1;
    for (int t = 0; t <= 4; t++) begin
      tick();
      model(t, ev, ed);
      chk("s5_pre_data", 64'(out_data), 64'(ed));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 64'(out_valid), 64'd0);
    chk("s5_rst_data", 64'(out_data), 64'd0);
    chk("s5_rst_done", 64'(done), 64'd0);
    chk("s5_rst_ready", 64'(in_ready), 64'd1);
    feed_en = 1'b0;
    tick();
    rst_n = 1'b1;
    last_d = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_no_done", 64'(done), 64'd0);
      chk("s5_no_valid", 64'(out_valid), 64'd0);
    end
    fill_random();
    load_tile(1'b0);
    feed(-1, 0);

    // random tiles with load gaps and random stalls
    for (int k = 0; k < 4; k++) begin
      fill_random();
      load_tile(1'b1);
      feed($urandom_range(0, 2 * N - 2), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
